// File: rtl/display_decoder.sv
// display_decoder: recovers a 4x4 multiplexed pixel frame (hours/minutes) from matrix pins.
// Ports: clk, rst (sync, active-high); pins_in {rows[3:0] one-cold active-low, cols[3:0]};
//        pixels/hours/minutes = last accepted frame; frame_valid, err_seq, err_range = one-cycle pulses;
//        locked = FSM in LOCKED; err_count = saturating error tally (ERR_W bits).
// Optional: DISPLAY_DECODER_RANGE_CHECK_EN rejects frames whose clock value is out of range.
module display_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       pins_in,
    output logic [15:0]      pixels,
    output logic [4:0]       hours,
    output logic [5:0]       minutes,
    output logic             frame_valid,
    output logic             locked,
    output logic             err_seq,
    output logic             err_range,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, HUNT, TRACK, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [7:0]       pins_q;
    logic [1:0]       exp_q, exp_d;
    logic [15:0]      shadow_q, shadow_d, pixels_q, pixels_d;
    logic             frame_valid_q, frame_valid_d, locked_q, locked_d;
    logic             err_seq_q, err_seq_d, err_range_q, err_range_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [3:0]       rows, cols;
    logic [1:0]       row_idx;
    logic             is_blank, is_row0, row_legal, frame_ok;
    logic [15:0]      frame;

    assign rows      = pins_q[7:4];
    assign cols      = pins_q[3:0];
    assign is_blank  = rows == 4'b0000;
    assign is_row0   = rows == 4'b1110;
    assign row_legal = is_row0 || rows == 4'b1101 || rows == 4'b1011 || rows == 4'b0111;
    assign row_idx   = rows == 4'b1101 ? 2'd1 : rows == 4'b1011 ? 2'd2 : rows == 4'b0111 ? 2'd3 : 2'd0;
    // Completed frame as it will look once the row3 nibble lands in the shadow.
    assign frame     = {cols, shadow_q[11:0]};

`ifdef DISPLAY_DECODER_RANGE_CHECK_EN
    assign frame_ok = frame[15:11] == 5'd0 && frame[10:6] <= 5'd23 && frame[5:0] <= 6'd59;
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        shadow_d      = shadow_q;
        pixels_d      = pixels_q;
        frame_valid_d = 1'b0;
        err_seq_d     = 1'b0;
        err_range_d   = 1'b0;
        if (is_blank) begin
            state_d  = IDLE;
            exp_d    = 2'd0;
            shadow_d = '0;
        end else if (state_q == IDLE || state_q == HUNT) begin
            state_d  = is_row0 ? TRACK : HUNT;
            exp_d    = is_row0 ? 2'd1 : 2'd0;
            shadow_d = is_row0 ? {12'h000, cols} : '0;
        end else if (row_legal && row_idx == exp_q) begin
            shadow_d[{row_idx, 2'b00} +: 4] = cols;
            exp_d = exp_q + 2'd1;
            if (row_idx == 2'd3) begin
                state_d       = LOCKED;
                pixels_d      = frame_ok ? frame : pixels_q;
                frame_valid_d = frame_ok;
                err_range_d   = !frame_ok;
            end
        end else begin
            // Sequence break: drop the partial frame; a row0 here immediately restarts capture.
            err_seq_d = 1'b1;
            state_d   = is_row0 ? TRACK : HUNT;
            exp_d     = is_row0 ? 2'd1 : 2'd0;
            shadow_d  = is_row0 ? {12'h000, cols} : '0;
        end
        locked_d    = state_d == LOCKED;
        err_count_d = (err_seq_d || err_range_d) && !(&err_count_q) ? err_count_q + ERR_W'(1) : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pins_q        <= '0;
            state_q       <= IDLE;
            exp_q         <= '0;
            shadow_q      <= '0;
            pixels_q      <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_seq_q     <= 1'b0;
            err_range_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            pins_q        <= pins_in;
            state_q       <= state_d;
            exp_q         <= exp_d;
            shadow_q      <= shadow_d;
            pixels_q      <= pixels_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            err_seq_q     <= err_seq_d;
            err_range_q   <= err_range_d;
            err_count_q   <= err_count_d;
        end
    end

    assign pixels      = pixels_q;
    assign hours       = pixels_q[10:6];
    assign minutes     = pixels_q[5:0];
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign err_seq     = err_seq_q;
    assign err_range   = err_range_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_display_decoder.sv
// tb_display_decoder: table-driven and directed sequence checks for display_decoder.
module tb_display_decoder;
    logic        clk, rst;
    logic [7:0]  pins_in;
    logic [15:0] pixels;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic        frame_valid, locked, err_seq, err_range;
    logic [7:0]  err_count;

    display_decoder #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst), .pins_in(pins_in), .pixels(pixels), .hours(hours),
        .minutes(minutes), .frame_valid(frame_valid), .locked(locked), .err_seq(err_seq),
        .err_range(err_range), .err_count(err_count)
    );

`ifdef DISPLAY_DECODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [15:0] pix;
        logic [4:0]  h;
        logic [5:0]  m;
        logic        bad;
    } vec_t;

    vec_t        tv [8];
    int          tests = 0, fails = 0;
    logic [15:0] exp_pix;
    logic [4:0]  exp_h;
    logic [5:0]  exp_m;
    int          exp_cnt;
    logic        acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rp(input int r, input logic [3:0] c);
        logic [3:0] one;
        one = 4'b0001 << r;
        return {~one, c};
    endfunction

    // Drive pins at a falling edge and advance to the next falling edge.
    task automatic cyc(input logic [7:0] p);
        pins_in = p;
        @(negedge clk);
    endtask

    task automatic frame4(input logic [15:0] f);
        for (int r = 0; r < 4; r++) cyc(rp(r, f[4*r +: 4]));
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_pix"}, pixels, exp_pix);
        chk({tag, "_h"}, hours, exp_h);
        chk({tag, "_m"}, minutes, exp_m);
        chk({tag, "_cnt"}, err_count, exp_cnt);
    endtask

    initial begin
        tv[0] = '{16'h036A, 5'd13, 6'd42, 1'b0};
        tv[1] = '{16'h0600, 5'd24, 6'd0,  1'b1};
        tv[2] = '{16'h05FB, 5'd23, 6'd59, 1'b0};
        tv[3] = '{16'h0000, 5'd0,  6'd0,  1'b0};
        tv[4] = '{16'h003C, 5'd0,  6'd60, 1'b1};
        tv[5] = '{16'h0800, 5'd0,  6'd0,  1'b1};
        tv[6] = '{16'h8001, 5'd0,  6'd1,  1'b1};
        tv[7] = '{16'h0271, 5'd9,  6'd49, 1'b0};
        exp_pix = '0; exp_h = '0; exp_m = '0; exp_cnt = 0;
        rst = 1'b1;
        pins_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk_hold("rst");
        chk("rst_fv", frame_valid, 0);
        chk("rst_lock", locked, 0);
        chk("rst_eseq", err_seq, 0);
        chk("rst_erng", err_range, 0);
        rst = 1'b0;
        cyc(8'h00);

        for (int i = 0; i < 8; i++) begin
            acc = !(RC && tv[i].bad);
            frame4(tv[i].pix);
            cyc(8'h00);
            if (acc) begin
                exp_pix = tv[i].pix; exp_h = tv[i].h; exp_m = tv[i].m;
            end else exp_cnt++;
            chk_hold($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_fv", i), frame_valid, acc);
            chk($sformatf("vec%0d_erng", i), err_range, !acc);
            chk($sformatf("vec%0d_eseq", i), err_seq, 0);
            chk($sformatf("vec%0d_lock", i), locked, 1);
            cyc(8'h00);
            chk($sformatf("vec%0d_fv_off", i), frame_valid, 0);
            chk($sformatf("vec%0d_unlock", i), locked, 0);
            chk_hold($sformatf("vec%0d_hold", i));
        end

        // Sequence error while locked, then recovery with a clean frame.
        frame4(16'h036A);
        cyc(rp(0, 4'h5));
        exp_pix = 16'h036A; exp_h = 5'd13; exp_m = 6'd42;
        chk("seq_fv", frame_valid, 1);
        chk("seq_lock", locked, 1);
        chk_hold("seq_frame");
        cyc(rp(2, 4'h1));
        chk("seq_r0_lock", locked, 1);
        chk("seq_r0_eseq", err_seq, 0);
        cyc(rp(0, 4'hA));
        exp_cnt++;
        chk("seq_eseq", err_seq, 1);
        chk("seq_err_lock", locked, 0);
        chk("seq_err_erng", err_range, 0);
        chk_hold("seq_err");
        cyc(rp(1, 4'h6));
        chk("seq_eseq_off", err_seq, 0);
        cyc(rp(2, 4'h3));
        cyc(rp(3, 4'h0));
        cyc(8'h00);
        chk("seq_rec_fv", frame_valid, 1);
        chk("seq_rec_lock", locked, 1);
        chk_hold("seq_rec");
        cyc(8'h00);

        // Blank mid-frame: back to IDLE, trailing rows must not form a frame.
        cyc(rp(0, 4'h1));
        cyc(rp(1, 4'h2));
        cyc(8'h00);
        cyc(rp(2, 4'h3));
        chk("blank_lock", locked, 0);
        chk("blank_eseq", err_seq, 0);
        cyc(rp(3, 4'h0));
        for (int k = 0; k < 3; k++) begin
            cyc(8'h00);
            chk($sformatf("blank_fv%0d", k), frame_valid, 0);
            chk($sformatf("blank_eseq%0d", k), err_seq, 0);
        end
        chk_hold("blank");

        // Saturation: 300 row0/illegal pairs, each pair one sequence error.
        for (int k = 0; k < 300; k++) begin
            cyc(rp(0, 4'h0));
            cyc(8'hF0);
            if (k == 5) chk("sat_mid", err_count, exp_cnt + 5);
        end
        cyc(8'h00);
        cyc(8'h00);
        exp_cnt = 255;
        chk_hold("sat");
        chk("sat_eseq_off", err_seq, 0);

        // Reset in the middle of a frame, then a normal frame.
        cyc(rp(0, 4'hA));
        cyc(rp(1, 4'h6));
        rst = 1'b1;
        cyc(rp(2, 4'h3));
        cyc(rp(3, 4'h0));
        exp_pix = '0; exp_h = '0; exp_m = '0; exp_cnt = 0;
        chk_hold("mrst");
        chk("mrst_fv", frame_valid, 0);
        chk("mrst_lock", locked, 0);
        chk("mrst_eseq", err_seq, 0);
        rst = 1'b0;
        frame4(16'h036A);
        cyc(8'h00);
        exp_pix = 16'h036A; exp_h = 5'd13; exp_m = 6'd42;
        chk("mrst_rec_fv", frame_valid, 1);
        chk("mrst_rec_lock", locked, 1);
        chk("mrst_rec_eseq", err_seq, 0);
        chk_hold("mrst_rec");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/display_decoder.md
DISPLAY_DECODER -- requirements
Module: display_decoder

Interface
REQ-001 Parameter ERR_W, default 8: width of err_count.
REQ-002 clk  input  1  system clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 pins_in  input  8  multiplexed matrix pins {rows[3:0], cols[3:0]}; rows one-cold, active-low.
REQ-005 pixels  output  16  last accepted frame, pixels[4*r+c] = cols[c] during row r.
REQ-006 hours  output  5  pixels[10:6].
REQ-007 minutes  output  6  pixels[5:0].
REQ-008 frame_valid  output  1  one-cycle pulse when pixels updates.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 err_seq  output  1  one-cycle pulse on row-sequence error.
REQ-011 err_range  output  1  one-cycle pulse on rejected out-of-range frame.
REQ-012 err_count  output  ERR_W  saturating count of err_seq plus err_range events.

Function
REQ-013 pins_in SHALL be registered once; all decoding SHALL use the registered copy.
REQ-014 Row decode: 1110->row0, 1101->row1, 1011->row2, 0111->row3, 0000->blank, any other code->illegal.
REQ-015 FSM states SHALL be IDLE, HUNT, TRACK, LOCKED.
REQ-016 IDLE: on any non-blank sample go HUNT; if that sample is row0, capture it and go TRACK directly.
REQ-017 HUNT: ignore rows 1-3 without error; on row0 capture cols into shadow nibble 0, expect row1, go TRACK.
REQ-018 TRACK/LOCKED: the expected row SHALL capture cols into its shadow nibble and advance expected row 0->1->2->3->0.
REQ-019 After the row3 capture, frame check SHALL run; on pass, pixels <= shadow and frame_valid pulses; the state becomes LOCKED.
REQ-020 Latency: pixels/frame_valid SHALL update on the second rising edge after the row3 value is present on pins_in.
REQ-021 In TRACK or LOCKED, an unexpected row or illegal code SHALL pulse err_seq, discard the shadow, drop locked, and go HUNT.
REQ-022 If that erroneous sample is row0, it SHALL also start a new capture (go TRACK, expecting row1).
REQ-023 Blank in any state SHALL go IDLE, discard the shadow, raise no error, and hold pixels.
REQ-024 err_count SHALL increment by one per error pulse and saturate at all-ones.
REQ-025 err_seq and err_range SHALL never assert in the same cycle.

Reset
REQ-026 During rst, state SHALL be IDLE; shadow, pixels, err_count, frame_valid, locked, err_seq and err_range SHALL all be 0.
REQ-027 rst mid-frame SHALL discard the partial frame, with no error pulse and no counter change.

Configuration
REQ-028 With DISPLAY_DECODER_RANGE_CHECK_EN defined, a frame with pixels[15:11]!=0, hours>23, or minutes>59 SHALL be rejected.
REQ-029 On rejection: pixels is held, err_range pulses, err_count increments, and state remains/becomes LOCKED.
REQ-030 Without DISPLAY_DECODER_RANGE_CHECK_EN, every complete frame SHALL be accepted and err_range SHALL be tied 0.

Verification
REQ-031 Basic capture: after rst, rows 1110/1101/1011/0111 with cols A/6/3/0 -> pixels=0x036A, hours=13, minutes=42, frame_valid one pulse, locked=1.
REQ-032 Sequence error: in LOCKED, feed row0 then row2 -> err_seq one pulse, err_count=1, locked=0, pixels unchanged; next clean frame -> locked=1.
REQ-033 Range check (macro on): frame 0x0600 (hours=24) -> err_range pulse, pixels holds 0x036A; macro off -> pixels=0x0600, frame_valid pulse.
REQ-034 Blank rows: rows=0000 mid-frame -> IDLE, no error, pixels held, locked=0.
REQ-035 Saturation: 300 illegal-code errors with ERR_W=8 -> err_count=255.
REQ-036 Reset mid-frame: assert rst after row1 -> all outputs 0; next full frame -> accepted normally.
